// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC, issues instruction-memory reads and
// registers the fetched word (or a NOP bubble) for the execute stage.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_007F
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        x_ctrl,
    input  logic [31:0] alu_out,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_F,
    output logic [31:0] pc_F,
    output logic        inst_valid,
    output logic        pc_sel,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'b00,
        FETCH = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] inst_nx, pcf_nx;
    logic        valid_nx, mis_nx;

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BOOT;
            pc           <= RESET_PC;
            inst_F       <= NOP_INST;
            pc_F         <= '0;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            inst_F       <= inst_nx;
            pc_F         <= pcf_nx;
            inst_valid   <= valid_nx;
            misalign_err <= mis_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        inst_nx  = inst_F;
        pcf_nx   = pc_F;
        valid_nx = inst_valid;
        mis_nx   = misalign_err;
        imem_req = (state == FETCH);
        pc_sel   = x_ctrl;

        // A redirect outranks stall and memory handshake; stall freezes everything else.
        if (x_ctrl) begin
            pc_nx    = {alu_out[31:1], 1'b0};
            inst_nx  = NOP_INST;
            valid_nx = 1'b0;
            state_nx = FLUSH;
            if (alu_out[1]) begin
                mis_nx = 1'b1;
            end
        end else if (!stall) begin
            case (state)
                BOOT: begin
                    state_nx = FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        inst_nx  = imem_rdata;
                        pcf_nx   = pc;
                        valid_nx = 1'b1;
                        pc_nx    = pc + 32'd4;
                    end else begin
                        inst_nx  = NOP_INST;
                        valid_nx = 1'b0;
                    end
                end
                FLUSH: begin
                    inst_nx  = NOP_INST;
                    valid_nx = 1'b0;
                    state_nx = FETCH;
                end
                default: begin
                    state_nx = BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized self-checking bench for fetch_ctrl against a behavioural fetch model
// whose instruction memory returns a fixed hash of the address.
module tb_fetch_ctrl;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_007F;
    localparam int M_BOOT  = 0;
    localparam int M_FETCH = 1;
    localparam int M_FLUSH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        x_ctrl = 1'b0;
    logic [31:0] alu_out = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst_F;
    logic [31:0] pc_F;
    logic        inst_valid;
    logic        pc_sel;
    logic        misalign_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int          m_mode;
    logic [31:0] m_pc, m_inst, m_pcf;
    logic        m_valid, m_mis;

    fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst_n(rst_n), .x_ctrl(x_ctrl), .alu_out(alu_out), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_F(inst_F), .pc_F(pc_F), .inst_valid(inst_valid),
        .pc_sel(pc_sel), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    task automatic check_regs();
        chk("inst_F", inst_F, m_inst);
        chk("pc_F", pc_F, m_pcf);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    // Called just after a falling edge; asserts reset without any clock edge.
    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        m_mode = M_BOOT; m_pc = RESET_PC; m_inst = NOP_INST;
        m_pcf = '0; m_valid = 1'b0; m_mis = 1'b0;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, RESET_PC);
        check_regs();
        #1 rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registers.
    task automatic step(input logic x, input logic [31:0] alu, input logic st, input logic rdy);
        x_ctrl = x; alu_out = alu; stall = st; imem_ready = rdy;
        imem_rdata = (rdy && !st) ? mem_word(m_pc) : $urandom;
        #1;
        chk("imem_req", {31'd0, imem_req}, (m_mode == M_FETCH) ? 32'd1 : 32'd0);
        chk("imem_addr", imem_addr, m_pc);
        chk("pc_sel", {31'd0, pc_sel}, {31'd0, x});
        @(posedge clk);
        if (x) begin
            m_pc = alu - (alu % 2);
            m_inst = NOP_INST; m_valid = 1'b0; m_mode = M_FLUSH;
            if ((alu / 2) % 2 == 1) m_mis = 1'b1;
        end else if (!st) begin
            if (m_mode == M_BOOT) begin
                m_mode = M_FETCH;
            end else if (m_mode == M_FLUSH) begin
                m_mode = M_FETCH; m_inst = NOP_INST; m_valid = 1'b0;
            end else if (rdy) begin
                m_inst = mem_word(m_pc); m_pcf = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
            end else begin
                m_inst = NOP_INST; m_valid = 1'b0;
            end
        end
        #1;
        check_regs();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        pulse_reset();

        // Steady stream, then a 3-cycle memory wait at 0x8
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        repeat (3) step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // Redirect during stall, odd target, then resume at 0x100
        step(1, 32'h0000_0101, 1, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // Misaligned target sets the sticky flag
        step(1, 32'h0000_0042, 0, 0);
        repeat (4) step(0, '0, 0, 1);

        // Wrap at top of address space, then a 2-cycle stall
        step(1, 32'hFFFF_FFFC, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 1, 1);
        step(0, '0, 1, 0);
        step(0, '0, 0, 1);

        // Back-to-back redirects: last wins
        step(1, 32'h0000_2000, 0, 1);
        step(1, 32'h0000_3000, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // Reset while flushing
        step(1, 32'h0000_0400, 0, 1);
        pulse_reset();
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) == 0) begin
                pulse_reset();
            end
            step($urandom_range(9) == 0, $urandom, $urandom_range(3) == 0,
                 $urandom_range(9) < 7);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_007F (opcode[6:2]=5'b11111), SHALL be the bubble instruction sent to execute.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 x_ctrl  input  1  SHALL mean execute stage requests PC redirect (taken branch/JAL/JALR) this cycle.
REQ-006 alu_out  input  32  SHALL be the redirect target from execute, valid when x_ctrl=1.
REQ-007 stall  input  1  SHALL mean downstream cannot accept a new instruction this cycle.
REQ-008 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-009 imem_addr  output  32  SHALL be the read address, equal to the internal PC register.
REQ-010 imem_ready  input  1  SHALL mean imem_rdata is valid for the current imem_addr.
REQ-011 imem_rdata  input  32  SHALL be the fetched instruction word.
REQ-012 inst_F  output  32  SHALL be the registered instruction passed to the execute latch.
REQ-013 pc_F  output  32  SHALL be the registered PC of inst_F.
REQ-014 inst_valid  output  1  SHALL be 1 when inst_F is a real fetched instruction, 0 for bubble.
REQ-015 pc_sel  output  1  SHALL be combinational: 1 when the PC mux selects alu_out this cycle.
REQ-016 misalign_err  output  1  SHALL be a sticky flag for a redirect target with bit1 set.

Function
REQ-017 FSM states SHALL be BOOT, FETCH and FLUSH; 2-bit encoding.
REQ-018 BOOT: imem_req=0; next state FETCH unconditionally (unless redirected, REQ-024).
REQ-019 FETCH: imem_req=1; imem_addr=PC.
REQ-020 FETCH, imem_ready=1, stall=0, x_ctrl=0: inst_F<=imem_rdata, pc_F<=PC, inst_valid<=1, PC<=PC+4; one-cycle latency from ready to inst_F.
REQ-021 FETCH, imem_ready=0, stall=0, x_ctrl=0: inst_F<=NOP_INST, inst_valid<=0, PC held, imem_req stays 1.
REQ-022 stall=1, x_ctrl=0: PC, inst_F, pc_F, inst_valid, state SHALL hold; imem_rdata ignored; imem_req unchanged.
REQ-023 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-024 x_ctrl=1 in any state SHALL take priority over stall and imem_ready: PC<={alu_out[31:1],1'b0}, inst_F<=NOP_INST, inst_valid<=0, pc_sel=1, state<=FLUSH; in-flight fetch discarded.
REQ-025 pc_sel SHALL be 0 whenever x_ctrl=0.
REQ-026 FLUSH: imem_req=0, inst_F<=NOP_INST, inst_valid<=0; next state FETCH; x_ctrl=1 in FLUSH re-applies REQ-024 and stays FLUSH.
REQ-027 Redirect with alu_out[1]=1 SHALL set misalign_err<=1; only reset clears it; PC still loads per REQ-024.
REQ-028 Back-to-back x_ctrl pulses SHALL each redirect; last one wins.

Reset
REQ-029 rst_n=0 SHALL immediately force: PC=RESET_PC, state=BOOT, imem_req=0, inst_F=NOP_INST, pc_F=0, inst_valid=0, misalign_err=0.
REQ-030 Reset asserted mid-fetch or mid-flush SHALL abandon the operation with no residual state; first request after release at RESET_PC, second cycle after release.

Verification
REQ-031 Release reset, imem_ready=1 constant, words A,B,C -> imem_addr 0,4,8; inst_F=A,B,C with pc_F 0,4,8, inst_valid=1, one cycle after each ready.
REQ-032 imem_ready low 3 cycles at PC=0x8 -> inst_F=0x0000_007F, inst_valid=0 for 3 cycles, imem_addr held 0x8, then instruction at 0x8 delivered.
REQ-033 x_ctrl=1, alu_out=0x0000_0101, stall=1 same cycle -> pc_sel=1, next imem_addr=0x0000_0100, one FLUSH cycle imem_req=0, NOP bubble, fetch resumes at 0x100.
REQ-034 Redirect to 0x0000_0042 -> misalign_err=1 and stays 1 across later fetches until rst_n=0.
REQ-035 PC=0xFFFF_FFFC with ready -> next imem_addr=0x0000_0000; stall=1 2 cycles mid-stream -> all outputs unchanged.
REQ-036 rst_n pulsed low during FLUSH -> outputs reset asynchronously; after release BOOT then fetch at RESET_PC.
